// File: rtl/mul_pkg.sv
// Shared definitions for the multiply functional unit and its result path.
// Op encodings follow the low bits of funct3 for the RV32M multiply group.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'd0,
        MUL_OP_MULH   = 2'd1,
        MUL_OP_MULHSU = 2'd2,
        MUL_OP_MULHU  = 2'd3
    } mul_op_t;

    localparam int unsigned FU_DATA_W   = 32;
    localparam int unsigned FU_ROB_IX_W = 3;

    // Result record common to all functional units feeding the CDB.
    typedef struct packed {
        logic [FU_DATA_W-1:0]   data;
        logic [FU_ROB_IX_W-1:0] rob_ix;
    } fu_result_t;

    // Returns {rs1_signed, rs2_signed}; MUL uses only the low half, so signedness is moot.
    function automatic logic [1:0] mul_op_signs(input mul_op_t op);
        logic [1:0] signs;
        signs = 2'b00;
        case (op)
            MUL_OP_MULH:   signs = 2'b11;
            MUL_OP_MULHSU: signs = 2'b10;
            default:       signs = 2'b00;
        endcase
        return signs;
    endfunction

endpackage

// File: rtl/fu_result_fifo.sv
// Synchronous in-order result FIFO with a combinational head and a clear input.
// Overflow is prevented upstream by credit accounting, so push is never refused.
module fu_result_fifo #(
    parameter int unsigned DATA_W = 35,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk_in,
    input  logic              clear_in,
    input  logic              push_in,
    input  logic [DATA_W-1:0] push_data_in,
    input  logic              pop_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] head_out
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid_out = (count_q != '0);
    assign head_out  = mem_q[rd_ptr_q];
    assign do_pop    = pop_in && valid_out;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_in) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push_in && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!push_in && do_pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (clear_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_in) mem_q[wr_ptr_q] <= push_data_in;
    end

endmodule

// File: rtl/mul_pipe_unit.sv
// Fully pipelined RV32M multiply unit: product formed in stage 0, delayed to a
// fixed latency, then parked in an in-order queue whose space is reserved at issue.
module mul_pipe_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned LATENCY   = 6,
    parameter int unsigned ROB_IX_W  = 3,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                flush_in,
    input  logic                valid_in,
    input  logic [1:0]          op_in,
    input  logic [WIDTH-1:0]    rval1_in,
    input  logic [WIDTH-1:0]    rval2_in,
    input  logic [ROB_IX_W-1:0] rob_ix_in,
    output logic                ready_out,
    output logic                valid_out,
    output logic [WIDTH-1:0]    data_out,
    output logic [ROB_IX_W-1:0] rob_ix_out,
    input  logic                read_in
);
    import mul_pkg::*;

    localparam int unsigned OCC_W = $clog2(OUT_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(OUT_DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0]    data;
        logic [ROB_IX_W-1:0] rob_ix;
    } stage_t;

    mul_op_t                   op;
    logic [1:0]                signs;
    logic signed [WIDTH:0]     a_ext, b_ext;
    logic signed [2*WIDTH+1:0] a_wide, b_wide, product;
    logic [WIDTH-1:0]          result;
    logic                      unused_product;

    logic                      accept, pop, clear;
    logic [LATENCY-1:0]        pipe_valid_q, pipe_valid_d;
    stage_t                    pipe_q [LATENCY];
    logic [OCC_W-1:0]          occ_q, occ_d;
    stage_t                    head;

    assign op     = mul_op_t'(op_in);
    assign signs  = mul_op_signs(op);
    assign a_ext  = {signs[1] & rval1_in[WIDTH-1], rval1_in};
    assign b_ext  = {signs[0] & rval2_in[WIDTH-1], rval2_in};
    assign a_wide = {{(WIDTH+1){a_ext[WIDTH]}}, a_ext};
    assign b_wide = {{(WIDTH+1){b_ext[WIDTH]}}, b_ext};
    assign product = a_wide * b_wide;
    assign result  = (op == MUL_OP_MUL) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];
    assign unused_product = ^product[2*WIDTH+1:2*WIDTH];

    // ready/valid depend only on registered state; flush/reset win over both handshakes.
    assign clear     = !rst_n_in || flush_in;
    assign ready_out = (occ_q < OCC_MAX);
    assign accept    = valid_in && ready_out && !flush_in;
    assign pop       = read_in && valid_out && !flush_in;

    always_comb begin
        pipe_valid_d    = '0;
        pipe_valid_d[0] = accept;
        for (int i = 1; i < int'(LATENCY); i++) pipe_valid_d[i] = pipe_valid_q[i-1];
        occ_d = occ_q;
        if (accept && !pop)      occ_d = occ_q + OCC_W'(1);
        else if (!accept && pop) occ_d = occ_q - OCC_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (clear) begin
            pipe_valid_q <= '0;
            occ_q        <= '0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            occ_q        <= occ_d;
        end
    end

    always_ff @(posedge clk_in) begin
        pipe_q[0] <= '{data: result, rob_ix: rob_ix_in};
        for (int i = 1; i < int'(LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
    end

    fu_result_fifo #(
        .DATA_W (WIDTH + ROB_IX_W),
        .DEPTH  (OUT_DEPTH)
    ) u_result_fifo (
        .clk_in       (clk_in),
        .clear_in     (clear),
        .push_in      (pipe_valid_q[LATENCY-1]),
        .push_data_in (pipe_q[LATENCY-1]),
        .pop_in       (pop),
        .valid_out    (valid_out),
        .head_out     (head)
    );

    assign data_out   = valid_out ? head.data : '0;
    assign rob_ix_out = valid_out ? head.rob_ix : '0;

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed bench for mul_pipe_unit: a depth-4 instance for most scenarios and a
// depth-6 instance for sustained back-to-back issue, both scoreboarded.
module tb_mul_pipe_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  rob;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Instance A: OUT_DEPTH = 4
    logic        flush_a = 0, valid_a = 0, read_a = 0;
    logic [1:0]  op_a = 0;
    logic [31:0] a_a = 0, b_a = 0;
    logic [2:0]  rob_in_a = 0;
    logic        ready_a, vout_a;
    logic [31:0] dout_a;
    logic [2:0]  rob_a;

    // Instance B: OUT_DEPTH = 6
    logic        flush_b = 0, valid_b = 0, read_b = 0;
    logic [1:0]  op_b = 0;
    logic [31:0] a_b = 0, b_b = 0;
    logic [2:0]  rob_in_b = 0;
    logic        ready_b, vout_b;
    logic [31:0] dout_b;
    logic [2:0]  rob_b;

    mul_pipe_unit #(.WIDTH(32), .LATENCY(6), .ROB_IX_W(3), .OUT_DEPTH(4)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush_a), .valid_in(valid_a),
        .op_in(op_a), .rval1_in(a_a), .rval2_in(b_a), .rob_ix_in(rob_in_a),
        .ready_out(ready_a), .valid_out(vout_a), .data_out(dout_a),
        .rob_ix_out(rob_a), .read_in(read_a)
    );

    mul_pipe_unit #(.WIDTH(32), .LATENCY(6), .ROB_IX_W(3), .OUT_DEPTH(6)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush_b), .valid_in(valid_b),
        .op_in(op_b), .rval1_in(a_b), .rval2_in(b_b), .rob_ix_in(rob_in_b),
        .ready_out(ready_b), .valid_out(vout_b), .data_out(dout_b),
        .rob_ix_out(rob_b), .read_in(read_b)
    );

    // Reference: plain 64-bit modular products of sign/zero-extended operands.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'd0:    begin p = ua * ub; return p[31:0]; end
            2'd1:    p = sa * sb;
            2'd2:    p = sa * ub;
            default: p = ua * ub;
        endcase
        return p[63:32];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: push on accept, pop/compare on CDB read, sampled mid-cycle.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst_n || flush_a) begin
            q_a.delete();
        end else begin
            if (q_a.size() == 0) check("idle_a_valid", 64'(vout_a), 64'd0);
            if (vout_a && read_a && q_a.size() > 0) begin
                e = q_a.pop_front();
                check("pop_a_data", 64'(dout_a), 64'(e.data));
                check("pop_a_rob", 64'(rob_a), 64'(e.rob));
            end
            if (valid_a && ready_a) q_a.push_back('{data: ref_mul(op_a, a_a, b_a), rob: rob_in_a});
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst_n || flush_b) begin
            q_b.delete();
        end else begin
            if (q_b.size() == 0) check("idle_b_valid", 64'(vout_b), 64'd0);
            if (vout_b && read_b && q_b.size() > 0) begin
                e = q_b.pop_front();
                check("pop_b_data", 64'(dout_b), 64'(e.data));
                check("pop_b_rob", 64'(rob_b), 64'(e.rob));
            end
            if (valid_b && ready_b) q_b.push_back('{data: ref_mul(op_b, a_b, b_b), rob: rob_in_b});
        end
    end

    // Single op into an empty unit A: checks latency, data and ROB tag, then pops it.
    task automatic run_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] rob, input logic [31:0] exp, input string tag);
        int lat;
        valid_a = 1; op_a = op; a_a = a; b_a = b; rob_in_a = rob;
        step();
        valid_a = 0;
        lat = 0;
        while (!vout_a && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd6);
        check({tag, "_data"}, 64'(dout_a), 64'(exp));
        check({tag, "_rob"}, 64'(rob_a), 64'(rob));
        read_a = 1;
        step();
        read_a = 0;
    endtask

    task automatic drain_a(input string tag);
        int n;
        read_a = 1;
        n = 0;
        while (q_a.size() != 0 && n < 40) begin
            step();
            n++;
        end
        check(tag, 64'(q_a.size()), 64'd0);
        read_a = 0;
    endtask

    initial begin
        int acc, low_at, n, cnt, first, last;
        logic took;

        repeat (3) step();
        check("rst_ready_a", 64'(ready_a), 64'd1);
        check("rst_valid_a", 64'(vout_a), 64'd0);
        check("rst_data_a", 64'(dout_a), 64'd0);
        check("rst_rob_a", 64'(rob_a), 64'd0);
        check("rst_ready_b", 64'(ready_b), 64'd1);
        check("rst_valid_b", 64'(vout_b), 64'd0);
        rst_n = 1;
        step();

        run_one(2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 3'd5, 32'hFFFF_FFEB, "mul");
        run_one(2'd1, 32'h8000_0000, 32'h8000_0000, 3'd1, 32'h4000_0000, "mulh");
        run_one(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 32'hFFFF_FFFE, "mulhu");
        run_one(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 32'hFFFF_FFFF, "mulhsu");
        run_one(2'd1, 32'h7FFF_FFFF, 32'h8000_0000, 3'd4, 32'hC000_0000, "mulh_mixed");

        // Back-to-back on the depth-6 instance with the CDB reading every cycle.
        read_b = 1;
        for (int i = 0; i < 6; i++) begin
            valid_b = 1; op_b = 2'(i % 4); a_b = $urandom; b_b = $urandom; rob_in_b = 3'(i);
            check("b2b_ready", 64'(ready_b), 64'd1);
            step();
        end
        valid_b = 0;
        cnt = 0; first = -1; last = -1;
        for (int c = 0; c < 12; c++) begin
            if (vout_b) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
            step();
        end
        check("b2b_count", 64'(cnt), 64'd6);
        check("b2b_consecutive", 64'(last - first), 64'd5);
        check("b2b_drained", 64'(q_b.size()), 64'd0);
        read_b = 0;

        // Backpressure: issuer holds its request until accepted.
        read_a = 0; acc = 0; low_at = -1;
        valid_a = 1; op_a = 2'd0; a_a = 32'd3; b_a = 32'd5; rob_in_a = 3'd0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            took = ready_a;
            if (!ready_a && low_at < 0) low_at = cyc;
            step();
            if (took) begin
                acc++;
                rob_in_a = 3'(acc); op_a = 2'(acc % 4); a_a = $urandom; b_a = $urandom;
            end
        end
        check("bp_accepted", 64'(acc), 64'd4);
        check("bp_ready_low_cycle", 64'(low_at), 64'd4);
        check("bp_ready_low", 64'(ready_a), 64'd0);
        n = 0;
        while (!vout_a && n < 20) begin
            step();
            n++;
        end
        check("bp_head_valid", 64'(vout_a), 64'd1);
        read_a = 1;
        step();
        read_a = 0;
        check("bp_ready_after_pop", 64'(ready_a), 64'd1);
        step();
        check("bp_fifth_accepted", 64'(ready_a), 64'd0);
        valid_a = 0;
        drain_a("bp_drain");

        // Flush with one result queued and three in flight.
        valid_a = 1; op_a = 2'd3; a_a = 32'h1234_5678; b_a = 32'h9ABC_DEF0; rob_in_a = 3'd0;
        step();
        valid_a = 0;
        n = 0;
        while (!vout_a && n < 20) begin
            step();
            n++;
        end
        check("fl_queued", 64'(vout_a), 64'd1);
        for (int i = 1; i < 4; i++) begin
            valid_a = 1; op_a = 2'(i); a_a = $urandom; b_a = $urandom; rob_in_a = 3'(i);
            step();
        end
        flush_a = 1; valid_a = 1; read_a = 1;
        step();
        flush_a = 0; valid_a = 0; read_a = 0;
        check("fl_valid", 64'(vout_a), 64'd0);
        check("fl_ready", 64'(ready_a), 64'd1);
        check("fl_data", 64'(dout_a), 64'd0);
        repeat (10) step();
        run_one(2'd0, 32'h0001_0000, 32'h0001_0000, 3'd6, 32'h0000_0000, "post_flush");

        // Reset with the queue full and a simultaneous issue and read.
        for (int i = 0; i < 4; i++) begin
            valid_a = 1; op_a = 2'd0; a_a = 32'(i + 2); b_a = 32'd9; rob_in_a = 3'(i);
            step();
        end
        valid_a = 0;
        repeat (8) step();
        check("full_valid", 64'(vout_a), 64'd1);
        check("full_ready", 64'(ready_a), 64'd0);
        rst_n = 0; valid_a = 1; read_a = 1;
        step();
        check("rst2_ready", 64'(ready_a), 64'd1);
        check("rst2_valid", 64'(vout_a), 64'd0);
        check("rst2_data", 64'(dout_a), 64'd0);
        check("rst2_rob", 64'(rob_a), 64'd0);
        rst_n = 1; valid_a = 0; read_a = 0;
        repeat (10) step();
        run_one(2'd0, 32'h0000_FFFF, 32'h0001_0001, 3'd7, 32'hFFFF_FFFF, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
